// File: rtl/uart_rx_param.sv
// UART receiver with oversampled, majority-voted bit recovery and a parameterised frame format.
// Latency: rx_valid rises 1 clk after the tick that takes the final stop-bit sample.
// Backpressure: one-word holding register; a frame completing while the word is unconsumed is dropped and overrun is set.
module uart_rx_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 rx_busy
);

    // Tick divider, rounded to the nearest integer clock count.
    localparam longint TICK_DEN      = longint'(BAUD) * longint'(OVERSAMPLE);
    localparam longint TICK_DEN_SAFE = (TICK_DEN > 0) ? TICK_DEN : 64'sd1;
    localparam int     DIV           = int'((longint'(CLK_FREQ) + TICK_DEN_SAFE / 2) / TICK_DEN_SAFE);

    localparam bit PARAMS_OK = (CLK_FREQ > 0) && (BAUD > 0) && (DIV >= 2)
                            && ((OVERSAMPLE == 8) || (OVERSAMPLE == 16) || (OVERSAMPLE == 32))
                            && (DATA_BITS >= 5) && (DATA_BITS <= 9)
                            && (PARITY >= 0) && (PARITY <= 2)
                            && ((STOP_BITS == 1) || (STOP_BITS == 2));

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("uart_rx_param: parameter out of range (DIV=%0d)", DIV);
        end
    endgenerate

    localparam int DIV_W = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam int PH_W  = (OVERSAMPLE >= 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W = (DATA_BITS >= 2) ? $clog2(DATA_BITS) : 1;

    // Majority-vote sample points straddle the bit centre; PH_END is the bit boundary.
    localparam logic [PH_W-1:0]  PH_A     = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0]  PH_B     = PH_W'(OVERSAMPLE / 2);
    localparam logic [PH_W-1:0]  PH_C     = PH_W'(OVERSAMPLE / 2 + 1);
    localparam logic [PH_W-1:0]  PH_END   = PH_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic             HAS_PAR   = (PARITY != 0) ? 1'b1 : 1'b0;
    localparam logic             ODD_PAR   = (PARITY == 2) ? 1'b1 : 1'b0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_BREAK = 3'd5;

    logic [DIV_W-1:0]     div_q;
    logic [1:0]           sync_q;
    logic [2:0]           state_q,  state_d;
    logic [PH_W-1:0]      phase_q,  phase_d;
    logic [BIT_W-1:0]     bit_q,    bit_d;
    logic                 stop_q,   stop_d;
    logic [1:0]           samp_q,   samp_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic                 zero_q,   zero_d;
    logic                 perr_q,   perr_d;
    logic                 ferr_q,   ferr_d;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_out_q;
    logic                 ferr_out_q;
    logic                 brk_out_q;
    logic                 ovr_q;

    logic tick;
    logic rxd_s;
    logic maj;
    logic done;
    logic done_ferr;
    logic done_brk;

    assign tick  = (div_q == DIV_W'(DIV - 1));
    assign rxd_s = sync_q[1];
    // Third vote is the live synced line, so the decision lands on the PH_C tick itself.
    assign maj   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);

    // Free-running oversample tick divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Two-flop synchroniser for the asynchronous line, idle-high reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    // Frame FSM next-state: everything advances only on ticks.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        stop_d    = stop_q;
        samp_d    = samp_q;
        shift_d   = shift_q;
        zero_d    = zero_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        done      = 1'b0;
        done_ferr = ferr_q | ~maj;
        done_brk  = zero_q & ~maj;
        if (tick) begin
            if (state_q != S_IDLE) begin
                phase_d = phase_q + 1'b1;
            end
            if (phase_q == PH_A) begin
                samp_d[0] = rxd_s;
            end
            if (phase_q == PH_B) begin
                samp_d[1] = rxd_s;
            end
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state_d = S_START;
                        bit_d   = '0;
                        stop_d  = 1'b0;
                        zero_d  = 1'b1;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
                S_START: begin
                    if (phase_q == PH_C && maj) begin
                        state_d = S_IDLE;
                        phase_d = '0;
                    end else if (phase_q == PH_END) begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (phase_q == PH_C) begin
                        shift_d = {maj, shift_q[DATA_BITS-1:1]};
                        if (maj) begin
                            zero_d = 1'b0;
                        end
                    end
                    if (phase_q == PH_END) begin
                        if (bit_q == BIT_LAST) begin
                            state_d = HAS_PAR ? S_PAR : S_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
                S_PAR: begin
                    if (phase_q == PH_C) begin
                        perr_d = maj ^ (^shift_q) ^ ODD_PAR;
                        if (maj) begin
                            zero_d = 1'b0;
                        end
                    end
                    if (phase_q == PH_END) begin
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (phase_q == PH_C) begin
                        ferr_d = done_ferr;
                        if (maj) begin
                            zero_d = 1'b0;
                        end
                        // The last stop sample closes the frame without waiting for the bit end.
                        if (stop_q == STOP_LAST) begin
                            done    = 1'b1;
                            phase_d = '0;
                            state_d = done_brk ? S_BREAK : S_IDLE;
                        end
                    end else if (phase_q == PH_END) begin
                        stop_d = 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rxd_s) begin
                        state_d = S_IDLE;
                        phase_d = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end
            endcase
        end
    end

    // Frame FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            samp_q  <= 2'b11;
            shift_q <= '0;
            zero_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            samp_q  <= samp_d;
            shift_q <= shift_d;
            zero_q  <= zero_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Holding register: loads on completion when free or being drained, else flags overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_out_q  <= 1'b0;
            ovr_q      <= 1'b0;
        end else if (done) begin
            if (!valid_q || rx_ready) begin
                data_q     <= shift_q;
                valid_q    <= 1'b1;
                perr_out_q <= perr_q;
                ferr_out_q <= done_ferr;
                brk_out_q  <= done_brk;
            end else begin
                ovr_q <= 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign break_det  = brk_out_q;
    assign overrun    = ovr_q;
    assign rx_busy    = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, ticks per bit; power of 2, 8..32.
REQ-004 SHALL have parameter DATA_BITS, default 8, data bits per frame, 5..9.
REQ-005 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-006 SHALL have parameter STOP_BITS, default 1, stop bits checked, 1 or 2.
REQ-007 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-008 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port rxd  input  1  asynchronous serial line, idle high.
REQ-010 SHALL have port rx_data  output  DATA_BITS  received word, LSB first on the line.
REQ-011 SHALL have port rx_valid  output  1  rx_data and error flags valid.
REQ-012 SHALL have port rx_ready  input  1  consumer accepts the word when rx_valid&rx_ready.
REQ-013 SHALL have port parity_err  output  1  parity mismatch for the held word.
REQ-014 SHALL have port frame_err  output  1  a stop sample was 0 for the held word.
REQ-015 SHALL have port break_det  output  1  held word is a line break.
REQ-016 SHALL have port overrun  output  1  sticky: at least one frame was dropped.
REQ-017 SHALL have port rx_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-018 SHALL generate a one-clk tick every DIV clocks, DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)); elaboration SHALL fail if DIV<2 or any parameter is out of range.
REQ-019 SHALL synchronise rxd through 2 flops clocked every clk, both reset to 1.
REQ-020 SHALL hold the tick phase counter (0..OVERSAMPLE-1) at 0 in IDLE and increment it on each tick otherwise.
REQ-021 SHALL sample each bit as the majority of the synced line at phases OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
REQ-022 SHALL use FSM states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-023 IDLE: on a tick with synced rxd=0, SHALL go to START.
REQ-024 START: if the start-bit majority is 1, SHALL return to IDLE (false start, no output); otherwise, at phase OVERSAMPLE-1, SHALL go to DATA.
REQ-025 DATA: SHALL shift DATA_BITS majority samples LSB first; at the end of the last bit SHALL go to PARITY if PARITY!=0, else to STOP.
REQ-026 PARITY: SHALL compare the sample with the XOR of the data bits (even) or its inverse (odd).
REQ-027 STOP: SHALL sample STOP_BITS stop bits; after the last stop-bit sample SHALL complete the frame in the same clk and go to IDLE without waiting for the bit end.
REQ-028 Break: if every data, parity and stop sample is 0, SHALL set break_det=1 and frame_err=1 and go to BREAK; BREAK SHALL return to IDLE only on a tick with synced rxd=1.
REQ-029 Completion: if rx_valid=0, or rx_valid&rx_ready in the same clk, SHALL load rx_data and the three error flags and drive rx_valid=1 on the next clk.
REQ-030 Completion with rx_valid=1 and rx_ready=0: SHALL discard the new frame, keep the held word and set overrun=1.
REQ-031 rx_valid&rx_ready without a completion SHALL clear rx_valid and overrun on the next clk.
REQ-032 rx_data and the error flags SHALL stay stable while rx_valid=1.
REQ-033 Latency SHALL be 1 clk from the final stop-sample tick to rx_valid.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE, with phase=0, divider=0, synchroniser=11, rx_data=0, and rx_valid, parity_err, frame_err, break_det, overrun and rx_busy all 0.
REQ-035 Reset release mid-frame SHALL resume in IDLE; the partial frame SHALL never be output.

Verification (CLK_FREQ=1600000, BAUD=10000, OVERSAMPLE=16 -> DIV=10, 160 clk/bit)
REQ-036 8N1, send 0xA5, rx_ready=1 -> one rx_valid pulse with rx_data=0xA5, all error flags 0.
REQ-037 PARITY=1, send 0x03 with parity bit 1 -> rx_data=0x03, parity_err=1; the same frame with parity bit 0 -> parity_err=0.
REQ-038 Send 0x5A with stop bit 0 -> frame_err=1, break_det=0; rxd low pulse of 48 clk -> no rx_valid, FSM back in IDLE.
REQ-039 rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11, overrun=1; one handshake -> rx_valid=0, overrun=0.
REQ-040 rxd low for 3200 clk -> rx_data=0x00, break_det=1, frame_err=1, no further frame until rxd high; rst_n pulsed during bit 4 of a frame -> no output, next frame 0x3C received correctly.
